// File: rtl/digit_entry.sv
// digit_entry: player-input front end for the memorization game.
// Debounces enter/backspace and assembles a 4-digit, 16-bit guess.

module digit_entry_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(CYCLES);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LIMIT) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // only a press (rising debounced level) is an event
  assign rise = level & ~level_d;
endmodule

module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MAX_DIGIT       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [3:0]  sw_digit,
  input  logic        btn_enter,
  input  logic        btn_back,
  output logic [15:0] user_int,
  output logic [2:0]  digit_count,
  output logic        entry_done,
  output logic        entry_valid,
  output logic        reject
);
  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  sw1;
  logic [3:0]  sw2;
  logic        enter_ev;
  logic        back_ev;
  logic [15:0] ui_nx;
  logic [2:0]  cnt_nx;
  logic        valid_nx;
  logic        rej_nx;

  digit_entry_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clk (clk),
    .rst (rst),
    .raw (btn_enter),
    .rise(enter_ev)
  );

  digit_entry_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_back (
    .clk (clk),
    .rst (rst),
    .raw (btn_back),
    .rise(back_ev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw1 <= 4'h0;
      sw2 <= 4'h0;
    end else begin
      sw1 <= sw_digit;
      sw2 <= sw1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      user_int    <= 16'h0000;
      digit_count <= 3'd0;
      entry_valid <= 1'b0;
      reject      <= 1'b0;
    end else begin
      state       <= state_nx;
      user_int    <= ui_nx;
      digit_count <= cnt_nx;
      entry_valid <= valid_nx;
      reject      <= rej_nx;
    end
  end

  // arm outranks everything; backspace outranks enter
  always_comb begin
    state_nx = state;
    ui_nx    = user_int;
    cnt_nx   = digit_count;
    valid_nx = 1'b0;
    rej_nx   = 1'b0;
    if (arm) begin
      state_nx = ENTRY;
      ui_nx    = 16'h0000;
      cnt_nx   = 3'd0;
    end else if (state == ENTRY) begin
      priority case (1'b1)
        back_ev: begin
          if (digit_count != 3'd0) begin
            ui_nx  = {4'h0, user_int[15:4]};
            cnt_nx = digit_count - 3'd1;
          end
        end
        enter_ev && (sw2 > MAX_D): begin
          rej_nx = 1'b1;
        end
        enter_ev: begin
          ui_nx  = {user_int[11:0], sw2};
          cnt_nx = digit_count + 3'd1;
          if (digit_count == 3'd3) begin
            state_nx = DONE;
            valid_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign entry_done = (state == DONE);
endmodule
